alu_wb_regs: RTL and testbench

Operand-fetch and writeback stage wrapped around the 8-bit `ALU` in mrhankey. Holds a 4-entry register file, issues operands and `op` to the ALU from a registered execute (E) stage, and writes `result` back one cycle later. It also maintains the processor status flags (C, V, Z, N) and a sticky overflow bit. The ALU stays purely combinational; this block supplies all sequencing, forwarding and stall handling around it.

---
 rtl/alu_wb_regs.sv | 161 ++++++++++++++++
 tb/tb_alu_wb_regs.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_regs.sv
// alu_wb_regs
//   Operand-fetch / writeback stage wrapped around a purely combinational
//   8-bit ALU. It holds a small register file and one registered execute (E)
//   stage that drives the ALU inputs. It writes the ALU result (or a load
//   immediate) back one cycle after issue. It also keeps the {N,Z,V,C} status
//   flags and a sticky overflow bit. A result still sitting in E is forwarded
//   to the next instruction, so dependent ops run back-to-back without bubbles.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready instruction handshake; in_ready = ~hold
//   in_op, in_ld, in_imm, in_rs_a, in_rs_b, in_rd, in_wen, in_flags_en
//                     instruction fields
//   hold              stall: freezes E, regfile, flags and wb_* data
//   alu_op/alu_a/alu_b registered ALU inputs (E stage)
//   alu_result/alu_cf/alu_ovf  ALU outputs
//   flags             {N,Z,V,C}
//   sticky_ovf/clr_sticky  sticky overflow and its clear
//   wb_valid/wb_data/wb_rd one-cycle writeback report
//   dbg_sel/dbg_data  combinational regfile read port (no forwarding)
module alu_wb_regs #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             in_ld,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [IW-1:0]    in_rs_a,
  input  logic [IW-1:0]    in_rs_b,
  input  logic [IW-1:0]    in_rd,
  input  logic             in_wen,
  input  logic             in_flags_en,
  input  logic             hold,
  output logic             alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_ovf,
  output logic [3:0]       flags,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic [IW-1:0]    wb_rd,
  input  logic [IW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  // E-stage bookkeeping that does not go to the ALU.
  logic             e_valid;
  logic [IW-1:0]    e_rd;
  logic             e_wen;
  logic             e_ld;
  logic [WIDTH-1:0] e_imm;
  logic             e_flags_en;

  logic             transfer;
  logic             wb_fire;
  logic             flag_upd;
  logic [WIDTH-1:0] wbv;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  assign in_ready = ~hold;
  assign transfer = in_valid & ~hold;
  assign wb_fire  = e_valid & ~hold;
  assign flag_upd = wb_fire & e_flags_en & ~e_ld;
  assign wbv      = e_ld ? e_imm : alu_result;
  assign dbg_data = regs[dbg_sel];

  // Operand forwarding: the value about to be written this edge wins over
  // the stale regfile entry.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    fwd_a = regs[in_rs_a];
    fwd_b = regs[in_rs_b];
    if (wb_fire && e_wen && (e_rd == in_rs_a)) fwd_a = wbv;
    if (wb_fire && e_wen && (e_rd == in_rs_b)) fwd_b = wbv;
  end

  // E stage. With no new instruction and no stall, the ALU inputs keep
  // their last values; only e_valid drops.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid    <= 1'b0;
      alu_op     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      e_rd       <= '0;
      e_wen      <= 1'b0;
      e_ld       <= 1'b0;
      e_imm      <= '0;
      e_flags_en <= 1'b0;
    end else if (!hold) begin
      e_valid <= transfer;
      if (transfer) begin
        alu_op     <= in_op;
        alu_a      <= fwd_a;
        alu_b      <= fwd_b;
        e_rd       <= in_rd;
        e_wen      <= in_wen;
        e_ld       <= in_ld;
        e_imm      <= in_imm;
        e_flags_en <= in_flags_en;
      end
    end
  end

  // Register file. dbg_data reads the array directly, so a same-edge write
  // becomes visible only after the edge.
  // NOTE: the register file is reset explicitly because software relies on
  // every register reading 0 after reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_fire && e_wen) begin
      regs[e_rd] <= wbv;
    end
  end

  // Writeback report. wb_valid is forced low while stalled; data is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else begin
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_data <= wbv;
        wb_rd   <= e_rd;
      end
    end
  end

  // Flags and sticky overflow. The clear is honoured during hold, and a
  // same-cycle overflow beats the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags      <= 4'b0000;
      sticky_ovf <= 1'b0;
    end else begin
      if (flag_upd) begin
        flags <= {alu_result[WIDTH-1], (alu_result == '0), alu_ovf, alu_cf};
      end
      sticky_ovf <= (sticky_ovf & ~clr_sticky) | (flag_upd & alu_ovf);
    end
  end

endmodule

// File: tb/tb_alu_wb_regs.sv
// Directed self-checking bench for alu_wb_regs. A small behavioural ALU
// (op=1 add, op=0 subtract) closes the loop around the DUT; every expected
// value below is worked out by hand from the instruction sequence.
module tb_alu_wb_regs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_op, in_ld, in_wen, in_flags_en, hold;
  logic [7:0] in_imm;
  logic [1:0] in_rs_a, in_rs_b, in_rd;
  logic       alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_cf, alu_ovf;
  logic [3:0] flags;
  logic       sticky_ovf, clr_sticky, wb_valid;
  logic [7:0] wb_data, dbg_data;
  logic [1:0] wb_rd, dbg_sel;

  int compares = 0;
  int fails    = 0;

  always #5 clk = ~clk;

  alu_wb_regs dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ld(in_ld),
    .in_imm(in_imm), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
    .in_wen(in_wen), .in_flags_en(in_flags_en), .hold(hold),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_ovf(alu_ovf),
    .flags(flags), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural ALU.
  logic [8:0] sum9;
  always_comb begin
    sum9       = alu_op ? ({1'b0, alu_a} + {1'b0, alu_b})
                        : ({1'b0, alu_a} - {1'b0, alu_b});
    alu_result = sum9[7:0];
    alu_cf     = sum9[8];
    alu_ovf    = alu_op ? ((alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]))
                        : ((alu_a[7] != alu_b[7]) && (sum9[7] != alu_a[7]));
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic ld, input logic [7:0] imm,
                       input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic wen, input logic fen);
    in_valid = 1'b1; in_op = op; in_ld = ld; in_imm = imm;
    in_rs_a = ra; in_rs_b = rb; in_rd = rd; in_wen = wen; in_flags_en = fen;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = 1'b0; in_ld = 1'b0; in_imm = '0;
    in_rs_a = '0; in_rs_b = '0; in_rd = '0; in_wen = 1'b0; in_flags_en = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] r,
                           input logic [7:0] exp);
    dbg_sel = r;
    #1;
    check(tag, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; clr_sticky = 1'b0; dbg_sel = '0;
    idle();
    #3;
    // Reset state
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_flags",    {28'b0, flags},    32'h0);
    check("rst_alu_a",    {24'b0, alu_a},    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and add with forwarding: ld r1=5, ld r2=43, add r3=r1+r2
    issue(1'b0, 1'b1, 8'd5, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    step();
    issue(1'b0, 1'b1, 8'd43, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    step();
    check("ld1_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("ld1_wb_data",  {24'b0, wb_data},  32'd5);
    check("ld1_wb_rd",    {30'b0, wb_rd},    32'd1);
    issue(1'b1, 1'b0, 8'd0, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1);
    step();
    check("ld2_wb_data",  {24'b0, wb_data},  32'd43);
    check("add_alu_a",    {24'b0, alu_a},    32'd5);
    check("add_alu_b_fwd",{24'b0, alu_b},    32'd43);
    idle();
    step();
    check("add_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("add_wb_data",  {24'b0, wb_data},  32'd48);
    check("add_wb_rd",    {30'b0, wb_rd},    32'd3);
    check("add_flags",    {28'b0, flags},    32'b0000);
    check_reg("add_r3", 2'd3, 8'd48);
    step();
    check("idle_wb_valid", {31'b0, wb_valid}, 32'd0);

    // Carry to zero: 0x80 + 0x80
    issue(1'b0, 1'b1, 8'h80, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    step();
    issue(1'b0, 1'b1, 8'h80, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    step();
    issue(1'b1, 1'b0, 8'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b1);
    step();
    idle();
    step();
    check("cz_wb_data", {24'b0, wb_data},   32'h00);
    check("cz_flags",   {28'b0, flags},     32'b0111);
    check("cz_sticky",  {31'b0, sticky_ovf}, 32'd1);
    check_reg("cz_r0", 2'd0, 8'h00);

    // Load with flags_en must not touch flags: ld r2=0
    issue(1'b0, 1'b1, 8'h00, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1);
    step();
    idle();
    step();
    check("ld_fen_flags", {28'b0, flags}, 32'b0111);
    check_reg("ld_fen_r2", 2'd2, 8'h00);

    // Sticky: lone clear, then clear racing an overflow, then lone clear
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_alone1", {31'b0, sticky_ovf}, 32'd0);
    issue(1'b1, 1'b0, 8'd0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b1); // r1+r1 = 0x80+0x80
    step();
    idle();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_race", {31'b0, sticky_ovf}, 32'd1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("clr_alone2", {31'b0, sticky_ovf}, 32'd0);

    // Hold: ld r1=7, ld r2=9, add r3=r1+r2 (flags_en) then stall 3 cycles
    issue(1'b0, 1'b1, 8'd7, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
    step();
    issue(1'b0, 1'b1, 8'd9, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
    step();
    issue(1'b1, 1'b0, 8'd0, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1);
    step();
    issue(1'b0, 1'b1, 8'hAA, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0); // must be blocked
    hold = 1'b1;
    #1;
    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_alu_a",    {24'b0, alu_a},    32'd7);
      check("hold_alu_b",    {24'b0, alu_b},    32'd9);
      check("hold_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("hold_wb_data",  {24'b0, wb_data},  32'd9);
      check_reg("hold_r3", 2'd3, 8'd48);
    end
    idle();
    hold = 1'b0;
    step();
    check("rel_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("rel_wb_data",  {24'b0, wb_data},  32'd16);
    check("rel_flags",    {28'b0, flags},    32'b0000);
    step();
    check("rel_single", {31'b0, wb_valid}, 32'd0);
    check_reg("rel_r3", 2'd3, 8'd16);
    check_reg("rel_r0", 2'd0, 8'h00);

    // No-write op: r1 - r3 = 7 - 16 = 0xF7, wen=0, flags_en=0
    issue(1'b0, 1'b0, 8'd0, 2'd1, 2'd3, 2'd1, 1'b0, 1'b0);
    step();
    idle();
    step();
    check("nw_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("nw_wb_data",  {24'b0, wb_data},  32'hF7);
    check("nw_flags",    {28'b0, flags},    32'b0000);
    check_reg("nw_r1", 2'd1, 8'd7);

    // Reset mid-operation: add in E, then asynchronous reset between edges
    issue(1'b1, 1'b0, 8'd0, 2'd1, 2'd3, 2'd2, 1'b1, 1'b1);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check("mrst_alu_a",   {24'b0, alu_a},    32'h0);
    check("mrst_wb_data", {24'b0, wb_data},  32'h0);
    check("mrst_in_ready",{31'b0, in_ready}, 32'd1);
    check_reg("mrst_r3", 2'd3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mrst_no_wb", {31'b0, wb_valid}, 32'd0);
    check_reg("mrst_r2", 2'd2, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
